mem_burst_reader: RTL and testbench



---
 rtl/mem_burst_reader.sv | 110 +++++++++++
 tb/tb_mem_burst_reader.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_burst_reader.sv
// Burst reader: splits a byte-length read request into 16-byte beats fetched from a
// combinational memory port and streams them out over a valid/ready interface.
module mem_burst_reader #(
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_data,
    output logic [4:0]       out_bytes,
    output logic             out_last,
    output logic             done,
    output logic             busy,
    output logic             interface_rdwr,
    output logic             interface_en,
    output logic [31:0]      interface_addr,
    input  logic [127:0]     interface_rd_data,
    output logic [127:0]     interface_wr_data,
    output logic [4:0]       interface_control
);

    localparam int BEAT_BYTES = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } state_t;

    state_t           state;
    logic [31:0]      cur_addr;
    logic [LEN_W-1:0] rem;
    logic             in_fetch;
    logic             fire;
    logic             last_beat;
    logic [4:0]       beat_size;

    // A beat is fetched whenever the output register is empty or being emptied this cycle.
    assign in_fetch  = (state == FETCH);
    assign fire      = in_fetch && (!out_valid || out_ready);
    assign last_beat = (rem <= LEN_W'(BEAT_BYTES));
    assign beat_size = last_beat ? 5'(rem) : 5'(BEAT_BYTES);

    assign cmd_ready         = (state == IDLE);
    assign busy              = (state != IDLE);
    assign interface_rdwr    = 1'b0;
    assign interface_wr_data = '0;
    assign interface_en      = fire;
    assign interface_addr    = in_fetch ? cur_addr : '0;
    assign interface_control = in_fetch ? beat_size : '0;

    // NOTE: every register here, including the 128-bit data holding register, is
    // cleared by the async reset so a mid-burst reset leaves no stale beat visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cur_addr  <= '0;
            rem       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_bytes <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; the default below makes done a
            // single-cycle pulse unless a branch re-asserts it.
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        cur_addr <= cmd_addr;
                        rem      <= cmd_len;
                        if (cmd_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (fire) begin
                        out_data  <= interface_rd_data;
                        out_bytes <= beat_size;
                        out_last  <= last_beat;
                        out_valid <= 1'b1;
                        cur_addr  <= cur_addr + 32'(BEAT_BYTES);
                        rem       <= rem - LEN_W'(beat_size);
                        if (last_beat) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_reader.sv
// Self-checking bench for mem_burst_reader: a masked memory responder plus a burst-level
// reference model (beat i at addr+16*i carrying min(16, len-16*i) bytes).
module tb_mem_burst_reader;

    logic         clk = 1'b0;
    logic         rst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  cmd_addr;
    logic [15:0]  cmd_len;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [4:0]   out_bytes;
    logic         out_last;
    logic         done;
    logic         busy;
    logic         interface_rdwr;
    logic         interface_en;
    logic [31:0]  interface_addr;
    logic [127:0] interface_rd_data;
    logic [127:0] interface_wr_data;
    logic [4:0]   interface_control;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    mem_burst_reader #(.LEN_W(16)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bytes(out_bytes), .out_last(out_last), .done(done), .busy(busy),
        .interface_rdwr(interface_rdwr), .interface_en(interface_en),
        .interface_addr(interface_addr), .interface_rd_data(interface_rd_data),
        .interface_wr_data(interface_wr_data), .interface_control(interface_control)
    );

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E37_79B1;
        return h[31:24] ^ a[7:0];
    endfunction

    function automatic logic [127:0] exp_beat(input logic [31:0] base, input int nb);
        logic [127:0] d;
        d = '0;
        for (int k = 0; k < nb; k++) d[8*k +: 8] = mem_byte(base + 32'(k));
        return d;
    endfunction

    // Memory returns requested bytes and zeros in the lanes above the byte count.
    always_comb begin
        interface_rd_data = '0;
        for (int k = 0; k < 16; k++)
            if (k < int'(interface_control))
                interface_rd_data[8*k +: 8] = mem_byte(interface_addr + 32'(k));
    end

    logic [127:0] beat_data_q[$];
    logic [4:0]   beat_bytes_q[$];
    logic         beat_last_q[$];
    logic [31:0]  fa_q[$];
    logic [4:0]   fc_q[$];
    int first_fetch_cyc, first_valid_cyc, done_cyc, last_hs_cyc;
    int bp_viol, hold_viol;
    logic ready_c0, busy_c0;

    // Issues one request (caller is 1 time unit past a rising edge) and records every
    // beat, fetch and the done cycle; mode 0 = always ready, 1 = toggle, 2 = random.
    task automatic run_burst(input logic [31:0] addr, input int len, input int mode,
                             input int max_cycles);
        logic         held_valid;
        logic [127:0] held_data;
        logic [4:0]   held_bytes;
        logic         held_last;
        beat_data_q.delete(); beat_bytes_q.delete(); beat_last_q.delete();
        fa_q.delete(); fc_q.delete();
        first_fetch_cyc = -1; first_valid_cyc = -1; done_cyc = -1; last_hs_cyc = -1;
        bp_viol = 0; hold_viol = 0; held_valid = 1'b0;
        held_data = '0; held_bytes = '0; held_last = 1'b0;
        cmd_valid = 1'b1; cmd_addr = addr; cmd_len = 16'(len);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < max_cycles; c++) begin
            out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (c % 2 == 1) : 1'($urandom_range(0, 1));
            @(negedge clk);
            if (c == 0) begin ready_c0 = cmd_ready; busy_c0 = busy; end
            if (held_valid && (!out_valid || out_data !== held_data ||
                               out_bytes !== held_bytes || out_last !== held_last))
                hold_viol++;
            held_valid = out_valid && !out_ready;
            held_data = out_data; held_bytes = out_bytes; held_last = out_last;
            if (interface_en) begin
                if (first_fetch_cyc < 0) first_fetch_cyc = c;
                fa_q.push_back(interface_addr);
                fc_q.push_back(interface_control);
                if (out_valid && !out_ready) bp_viol++;
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = c;
            if (out_valid && out_ready) begin
                beat_data_q.push_back(out_data);
                beat_bytes_q.push_back(out_bytes);
                beat_last_q.push_back(out_last);
                if (out_last) last_hs_cyc = c;
            end
            if (done) done_cyc = c;
            @(posedge clk); #1;
            if (done_cyc >= 0) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; out_ready = 1'b0;
        #3;
        total++;
        if ({cmd_ready, out_valid, out_last, done, busy, interface_en, interface_rdwr} !== 7'b1000000)
            $display("FAIL reset_flags got=%b want=1000000",
                     {cmd_ready, out_valid, out_last, done, busy, interface_en, interface_rdwr});
        else passed++;
        total++;
        if (out_data !== '0 || out_bytes !== '0 || interface_addr !== '0 ||
            interface_control !== '0 || interface_wr_data !== '0)
            $display("FAIL reset_values data=%h bytes=%0d iaddr=%h ictl=%0d want all zero",
                     out_data, out_bytes, interface_addr, interface_control);
        else passed++;
        #20;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        run_burst(32'h10, 16, 0, 40);
        total++;
        if (beat_data_q.size() !== 1) $display("FAIL single_count got=%0d want=1", beat_data_q.size());
        else passed++;
        if (beat_data_q.size() > 0) begin
            total++;
            if (beat_data_q[0] !== exp_beat(32'h10, 16) || beat_bytes_q[0] !== 5'd16 || beat_last_q[0] !== 1'b1)
                $display("FAIL single_beat data=%h bytes=%0d last=%b want data=%h bytes=16 last=1",
                         beat_data_q[0], beat_bytes_q[0], beat_last_q[0], exp_beat(32'h10, 16));
            else passed++;
        end
        total++;
        if (first_fetch_cyc !== 0 || first_valid_cyc !== 1)
            $display("FAIL single_latency fetch=%0d valid=%0d want fetch=0 valid=1", first_fetch_cyc, first_valid_cyc);
        else passed++;
        total++;
        if (last_hs_cyc < 0 || done_cyc !== last_hs_cyc + 1)
            $display("FAIL single_done done_cyc=%0d want=%0d", done_cyc, last_hs_cyc + 1);
        else passed++;
        total++;
        if (busy_c0 !== 1'b1 || ready_c0 !== 1'b0)
            $display("FAIL single_busy busy=%b cmd_ready=%b want busy=1 cmd_ready=0", busy_c0, ready_c0);
        else passed++;
    endtask

    task automatic test_multi();
        logic [4:0] want_ctl[3];
        want_ctl = '{5'd16, 5'd16, 5'd8};
        run_burst(32'h20, 40, 0, 40);
        total++;
        if (beat_data_q.size() !== 3 || fc_q.size() !== 3)
            $display("FAIL multi_count beats=%0d fetches=%0d want=3", beat_data_q.size(), fc_q.size());
        else passed++;
        for (int i = 0; i < 3 && i < fc_q.size() && i < beat_data_q.size(); i++) begin
            total++;
            if (fc_q[i] !== want_ctl[i] || fa_q[i] !== 32'h20 + 32'(16 * i) ||
                beat_data_q[i] !== exp_beat(32'h20 + 32'(16 * i), int'(want_ctl[i])) ||
                beat_bytes_q[i] !== want_ctl[i] || beat_last_q[i] !== (i == 2))
                $display("FAIL multi_beat%0d ctl=%0d addr=%h bytes=%0d last=%b data=%h want ctl=%0d addr=%h",
                         i, fc_q[i], fa_q[i], beat_bytes_q[i], beat_last_q[i], beat_data_q[i],
                         want_ctl[i], 32'h20 + 32'(16 * i));
            else passed++;
        end
        if (beat_data_q.size() == 3) begin
            total++;
            if (beat_data_q[2][127:64] !== 64'h0)
                $display("FAIL multi_upper_lanes got=%h want=0", beat_data_q[2][127:64]);
            else passed++;
        end
    endtask

    task automatic test_backpressure();
        run_burst(32'h100, 48, 1, 60);
        total++;
        if (bp_viol !== 0) $display("FAIL bp_fetch_while_stalled count=%0d want=0", bp_viol);
        else passed++;
        total++;
        if (hold_viol !== 0) $display("FAIL bp_hold count=%0d want=0", hold_viol);
        else passed++;
        total++;
        if (beat_data_q.size() !== 3) $display("FAIL bp_count got=%0d want=3", beat_data_q.size());
        else passed++;
        for (int i = 0; i < beat_data_q.size() && i < 3; i++) begin
            total++;
            if (beat_data_q[i] !== exp_beat(32'h100 + 32'(16 * i), 16))
                $display("FAIL bp_beat%0d got=%h want=%h", i, beat_data_q[i], exp_beat(32'h100 + 32'(16 * i), 16));
            else passed++;
        end
        total++;
        if (last_hs_cyc < 0 || done_cyc !== last_hs_cyc + 1)
            $display("FAIL bp_done done_cyc=%0d want=%0d", done_cyc, last_hs_cyc + 1);
        else passed++;
    endtask

    task automatic test_zero();
        run_burst(32'h40, 0, 0, 10);
        total++;
        if (first_valid_cyc !== -1 || first_fetch_cyc !== -1)
            $display("FAIL zero_activity valid_cyc=%0d fetch_cyc=%0d want none", first_valid_cyc, first_fetch_cyc);
        else passed++;
        total++;
        if (done_cyc !== 0 || ready_c0 !== 1'b1)
            $display("FAIL zero_done done_cyc=%0d cmd_ready=%b want done_cyc=0 cmd_ready=1", done_cyc, ready_c0);
        else passed++;
    endtask

    task automatic test_wrap();
        run_burst(32'hFFFF_FFF0, 32, 0, 40);
        total++;
        if (fa_q.size() !== 2) $display("FAIL wrap_count got=%0d want=2", fa_q.size());
        else if (fa_q[0] !== 32'hFFFF_FFF0 || fa_q[1] !== 32'h0)
            $display("FAIL wrap_addr got=%h,%h want=fffffff0,00000000", fa_q[0], fa_q[1]);
        else passed++;
        total++;
        if (beat_data_q.size() !== 2 || beat_data_q[1] !== exp_beat(32'h0, 16))
            $display("FAIL wrap_data beats=%0d want=2 with second beat from address 0", beat_data_q.size());
        else passed++;
    endtask

    task automatic test_mid_reset();
        int hs = 0;
        int bad = 0;
        cmd_valid = 1'b1; cmd_addr = 32'h200; cmd_len = 16'd64; out_ready = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 20 && hs < 2; c++) begin
            @(negedge clk);
            if (out_valid && out_ready) hs++;
            @(posedge clk);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if ({cmd_ready, out_valid, out_last, done, busy, interface_en} !== 6'b100000 ||
            out_data !== '0 || out_bytes !== '0 || interface_addr !== '0 || interface_control !== '0)
            $display("FAIL midrst_values flags=%b data=%h bytes=%0d iaddr=%h want flags=100000 rest zero",
                     {cmd_ready, out_valid, out_last, done, busy, interface_en}, out_data, out_bytes, interface_addr);
        else passed++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done || out_valid) bad++;
        end
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (done || out_valid || interface_en) bad++;
        end
        total++;
        if (bad !== 0) $display("FAIL midrst_quiet events=%0d want=0", bad);
        else passed++;
        @(posedge clk); #1;
        run_burst(32'h300, 16, 0, 40);
        total++;
        if (beat_data_q.size() !== 1 || beat_data_q[0] !== exp_beat(32'h300, 16) ||
            done_cyc !== last_hs_cyc + 1 || last_hs_cyc < 0)
            $display("FAIL midrst_recover beats=%0d done_cyc=%0d last_cyc=%0d want 1 beat, done one after",
                     beat_data_q.size(), done_cyc, last_hs_cyc);
        else passed++;
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            logic [31:0] addr;
            int len, n, nb;
            addr = $urandom;
            if (it % 3 == 0) addr = 32'hFFFF_FF80 + 32'($urandom_range(0, 127));
            len = int'($urandom_range(0, 90));
            n = (len + 15) / 16;
            run_burst(addr, len, 2, 400);
            total++;
            if (beat_data_q.size() !== n || fa_q.size() !== n)
                $display("FAIL rand%0d_count beats=%0d fetches=%0d want=%0d", it, beat_data_q.size(), fa_q.size(), n);
            else passed++;
            for (int i = 0; i < n && i < beat_data_q.size() && i < fa_q.size(); i++) begin
                nb = (len - 16 * i > 16) ? 16 : len - 16 * i;
                total++;
                if (fa_q[i] !== addr + 32'(16 * i) || beat_bytes_q[i] !== 5'(nb) ||
                    beat_last_q[i] !== (i == n - 1) || beat_data_q[i] !== exp_beat(addr + 32'(16 * i), nb))
                    $display("FAIL rand%0d_beat%0d addr=%h bytes=%0d last=%b data=%h want addr=%h bytes=%0d data=%h",
                             it, i, fa_q[i], beat_bytes_q[i], beat_last_q[i], beat_data_q[i],
                             addr + 32'(16 * i), nb, exp_beat(addr + 32'(16 * i), nb));
                else passed++;
            end
            total++;
            if (bp_viol !== 0 || hold_viol !== 0)
                $display("FAIL rand%0d_flow stalled_fetches=%0d hold_errors=%0d want 0", it, bp_viol, hold_viol);
            else passed++;
            total++;
            if ((n == 0 && done_cyc !== 0) || (n > 0 && (last_hs_cyc < 0 || done_cyc !== last_hs_cyc + 1)))
                $display("FAIL rand%0d_done done_cyc=%0d last_cyc=%0d len=%0d", it, done_cyc, last_hs_cyc, len);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_zero();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
